// File: rtl/mem_arb_ctrl_if.sv
// Request/memory bus bundle for mem_arb_ctrl.
// master: requesters plus memory model side; slave: the arbiter/controller.
interface mem_arb_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int AW     = 16,
    parameter int DW     = 16
) ();
    // Requester side
    logic [NUM_CH-1:0]    I_exec;
    logic [NUM_CH-1:0]    I_write;
    logic [2*NUM_CH-1:0]  I_size;
    logic [AW*NUM_CH-1:0] I_addr;
    logic [DW*NUM_CH-1:0] I_data;
    logic [NUM_CH-1:0]    O_ack;
    logic [NUM_CH-1:0]    O_ready;
    logic [DW-1:0]        O_data;
    logic [NUM_CH-1:0]    O_data_ready;
    logic [NUM_CH-1:0]    O_error;

    // Memory side
    logic                 MEM_ready;
    logic [DW-1:0]        MEM_data_in;
    logic                 MEM_data_ready;
    logic                 MEM_exec;
    logic                 MEM_write;
    logic [1:0]           MEM_size;
    logic [AW-1:0]        MEM_addr;
    logic [DW-1:0]        MEM_data_out;

    modport master (
        output I_exec, I_write, I_size, I_addr, I_data,
        input  O_ack, O_ready, O_data, O_data_ready, O_error,
        output MEM_ready, MEM_data_in, MEM_data_ready,
        input  MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
    );

    modport slave (
        input  I_exec, I_write, I_size, I_addr, I_data,
        output O_ack, O_ready, O_data, O_data_ready, O_error,
        input  MEM_ready, MEM_data_in, MEM_data_ready,
        output MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Multi-channel memory controller: NUM_CH requesters share one memory port.
// Round-robin grant, one transaction in flight, command fields registered at
// grant, read timeout with per-channel error pulse.
module mem_arb_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          I_clk,
    input  logic          I_reset,
    mem_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int LGW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [LGW-1:0] LG_RESET = LGW'(NUM_CH - 1);

    state_t             state_q, state_d;
    logic [LGW-1:0]     lg_q, lg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]  ack_q, ack_d;
    logic [NUM_CH-1:0]  dr_q, dr_d;
    logic [NUM_CH-1:0]  err_q, err_d;
    logic [DW-1:0]      odata_q, odata_d;
    logic               mexec_q, mexec_d;
    logic               mwrite_q, mwrite_d;
    logic [1:0]         msize_q, msize_d;
    logic [AW-1:0]      maddr_q, maddr_d;
    logic [DW-1:0]      mdata_q, mdata_d;

    logic               grant_vld;
    logic [LGW-1:0]     grant_ch;
    int unsigned        arb_sum;

    logic [1:0]         size_ch  [NUM_CH];
    logic [AW-1:0]      addr_ch  [NUM_CH];
    logic [DW-1:0]      data_ch  [NUM_CH];

    // Unpack the flat per-channel request buses into indexable arrays
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign size_ch[i] = bus.I_size[2*i +: 2];
        assign addr_ch[i] = bus.I_addr[AW*i +: AW];
        assign data_ch[i] = bus.I_data[DW*i +: DW];
    end

    // Round-robin pick: first active request after the last granted channel
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        arb_sum   = 0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            arb_sum = 32'(lg_q) + off;
            if (arb_sum >= 32'(NUM_CH)) begin
                arb_sum = arb_sum - 32'(NUM_CH);
            end
            if (!grant_vld && bus.I_exec[LGW'(arb_sum)]) begin
                grant_vld = 1'b1;
                grant_ch  = LGW'(arb_sum);
            end
        end
    end

    // Next-state and next-output logic; pulses default low, held fields keep value
    always_comb begin
        state_d  = state_q;
        lg_d     = lg_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        dr_d     = '0;
        err_d    = '0;
        odata_d  = odata_q;
        mexec_d  = 1'b0;
        mwrite_d = mwrite_q;
        msize_d  = msize_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.MEM_ready && grant_vld) begin
                    mexec_d          = 1'b1;
                    mwrite_d         = bus.I_write[grant_ch];
                    msize_d          = size_ch[grant_ch];
                    maddr_d          = addr_ch[grant_ch];
                    mdata_d          = data_ch[grant_ch];
                    ack_d[grant_ch]  = 1'b1;
                    lg_d             = grant_ch;
                    cnt_d            = '0;
                    state_d          = bus.I_write[grant_ch] ? DRAIN : RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Data takes priority over a timeout landing in the same cycle
                if (bus.MEM_data_ready) begin
                    odata_d    = bus.MEM_data_in;
                    dr_d[lg_q] = 1'b1;
                    state_d    = DRAIN;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == TO_LAST) begin
                        err_d[lg_q] = 1'b1;
                        state_d     = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.MEM_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= IDLE;
            lg_q     <= LG_RESET;
            cnt_q    <= '0;
            ack_q    <= '0;
            dr_q     <= '0;
            err_q    <= '0;
            odata_q  <= '0;
            mexec_q  <= 1'b0;
            mwrite_q <= 1'b0;
            msize_q  <= '0;
            maddr_q  <= '0;
            mdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            lg_q     <= lg_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            dr_q     <= dr_d;
            err_q    <= err_d;
            odata_q  <= odata_d;
            mexec_q  <= mexec_d;
            mwrite_q <= mwrite_d;
            msize_q  <= msize_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
        end
    end

    assign bus.O_ready      = (state_q == IDLE && bus.MEM_ready) ? ~bus.I_exec : '0;
    assign bus.O_ack        = ack_q;
    assign bus.O_data       = odata_q;
    assign bus.O_data_ready = dr_q;
    assign bus.O_error      = err_q;
    assign bus.MEM_exec     = mexec_q;
    assign bus.MEM_write    = mwrite_q;
    assign bus.MEM_size     = msize_q;
    assign bus.MEM_addr     = maddr_q;
    assign bus.MEM_data_out = mdata_q;

endmodule
